// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes, packs them little-endian into LANES-wide words on a valid/ready port.
// Optional idle auto-flush is built when PACKER_TIMEOUT_EN is defined.
module fifo_rd_packer #(
   parameter int unsigned DSIZE   = 8,
   parameter int unsigned LANES   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                       rclk,
   input  logic                       rrst,
   input  logic [DSIZE-1:0]           rdata,
   input  logic                       rempty,
   output logic                       rinc,
   input  logic                       flush,
   output logic [DSIZE*LANES-1:0]     out_data,
   output logic [$clog2(LANES):0]     out_bytes,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int unsigned CW = $clog2(LANES);
   localparam int unsigned BW = CW + 1;
   localparam int unsigned WW = DSIZE * LANES;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   acc_q, acc_d;
   logic [WW-1:0]   out_data_q, out_data_d;
   logic [BW-1:0]   out_bytes_q, out_bytes_d;
   logic            out_valid_q, out_valid_d;

   logic            pop;
   logic            tmo_flush;
   logic            flush_eff;

   // Pop strobe is combinational so a byte can be consumed every FILL cycle.
   assign pop       = (state_q == FILL) && !rempty;
   assign rinc      = pop && !rrst;
   assign flush_eff = flush || tmo_flush;

`ifdef PACKER_TIMEOUT_EN
   logic [15:0] idle_q, idle_d;

   assign tmo_flush = (idle_q == 16'(TIMEOUT));

   always_comb begin
      idle_d = idle_q;
      if (state_q == FILL) begin
         if (pop || (state_d == HOLD)) begin
            idle_d = 16'd0;
         end else if (cnt_q != CW'(0)) begin
            idle_d = idle_q + 16'd1;
         end
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         idle_q <= 16'd0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   // No idle counter; the term only references TIMEOUT and is always 0.
   assign tmo_flush = 1'b0 && (TIMEOUT != 0);
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_valid_d = out_valid_q;

      case (state_q)
         FILL: begin
            if (pop) begin
               acc_d[cnt_q*DSIZE +: DSIZE] = rdata;
               cnt_d                       = cnt_q + CW'(1);
            end
            if (pop && (cnt_q == CW'(LANES - 1))) begin
               state_d     = HOLD;
               out_data_d  = acc_d;
               out_bytes_d = BW'(LANES);
               out_valid_d = 1'b1;
            end else if (flush_eff && ((cnt_q != CW'(0)) || pop)) begin
               // A byte popped alongside flush is part of the emitted word.
               state_d     = HOLD;
               out_data_d  = acc_d;
               out_bytes_d = BW'(cnt_q) + BW'(pop);
               out_valid_d = 1'b1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = FILL;
               cnt_d       = CW'(0);
               acc_d       = WW'(0);
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q     <= FILL;
         cnt_q       <= CW'(0);
         acc_q       <= WW'(0);
         out_data_q  <= WW'(0);
         out_bytes_q <= BW'(0);
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_bytes = out_bytes_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FWFT byte FIFO model, full words, flush, reset, idle timeout.
module tb_fifo_rd_packer;
   localparam int unsigned DSIZE   = 8;
   localparam int unsigned LANES   = 4;
   localparam int unsigned TIMEOUT = 8;

   logic        rclk = 1'b0;
   logic        rrst;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready;

   logic [7:0]  fq[$];
   logic        last_pop;
   int          n_cmp = 0;
   int          n_err = 0;

   fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
      .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
      .flush(flush), .out_data(out_data), .out_bytes(out_bytes),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      rempty = (fq.size() == 0);
      rdata  = rempty ? 8'h00 : fq[0];
   endtask

   // One rclk cycle: capture the pop strobe before the edge, retire the head after it.
   task automatic tick();
      refresh();
      #1;
      last_pop = rinc;
      @(posedge rclk);
      #1;
      if (last_pop) void'(fq.pop_front());
      refresh();
      #1;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d, input logic [2:0] b);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"},  64'(out_data),  64'(d));
      chk({tag, "_bytes"}, 64'(out_bytes), 64'(b));
   endtask

   initial begin
      rrst      = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      last_pop  = 1'b0;
      refresh();
      repeat (2) @(posedge rclk);
      #2;

      // Reset state, with bytes already waiting
      for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
      refresh();
      #1;
      chk("rst_rinc",  64'(rinc),      64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data",  64'(out_data),  64'd0);
      chk("rst_bytes", 64'(out_bytes), 64'd0);

      // Full word, consumer always ready
      rrst      = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) chk($sformatf("t1_novalid%0d", i), 64'(out_valid), 64'd0);
         tick();
         chk($sformatf("t1_pop%0d", i), 64'(last_pop), 64'd1);
      end
      chk_word("t1", 32'h04030201, 3'd4);
      chk("t1_hold_rinc", 64'(rinc), 64'd0);
      tick();
      chk("t1_xfer_valid", 64'(out_valid), 64'd0);

      // Back-pressure: word held 5 cycles, flush ignored in HOLD
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
      repeat (4) tick();
      chk_word("t2", 32'h13121110, 3'd4);
      for (int k = 0; k < 5; k++) begin
         flush = (k == 2);
         tick();
         flush = 1'b0;
         chk($sformatf("t2_stall_data%0d", k), 64'(out_data), 64'h13121110);
         chk($sformatf("t2_stall_pop%0d", k),  64'(last_pop), 64'd0);
      end
      chk_word("t2_after_stall", 32'h13121110, 3'd4);
      out_ready = 1'b1;
      tick();
      chk("t2_hs_pop",   64'(last_pop),  64'd0);
      chk("t2_hs_valid", 64'(out_valid), 64'd0);
      tick();
      chk("t2_resume_pop", 64'(last_pop), 64'd1);
      repeat (3) tick();
      chk_word("t2b", 32'h17161514, 3'd4);
      tick();

      // Explicit flush of a 2-byte partial word
      fq.push_back(8'hAA);
      fq.push_back(8'hBB);
      tick();
      tick();
      chk("t3_novalid", 64'(out_valid), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk_word("t3", 32'h0000BBAA, 3'd2);
      tick();
      chk("t3_xfer_valid", 64'(out_valid), 64'd0);

      // Flush with nothing accumulated and FIFO empty is ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_empty_flush", 64'(out_valid), 64'd0);

      // Flush coincident with the 3rd pop keeps that byte
      fq.push_back(8'h11);
      fq.push_back(8'h22);
      fq.push_back(8'h33);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_pop", 64'(last_pop), 64'd1);
      chk_word("t4", 32'h00332211, 3'd3);
      chk("t4_fifo_empty", 64'(fq.size()), 64'd0);
      tick();

      // Async reset mid-word discards the partial bytes
      fq.push_back(8'hE1);
      fq.push_back(8'hE2);
      tick();
      tick();
      rrst = 1'b1;
      #1;
      chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_data",  64'(out_data),  64'd0);
      for (int i = 5; i <= 8; i++) fq.push_back(8'(i));
      refresh();
      #1;
      chk("t5_rst_rinc", 64'(rinc), 64'd0);
      @(posedge rclk);
      #2;
      chk("t5_rst_nopop", 64'(fq.size()), 64'd4);
      rrst = 1'b0;
      repeat (4) tick();
      chk_word("t5", 32'h08070605, 3'd4);
      tick();

      // Idle timeout on a single byte
      fq.push_back(8'h5A);
      tick();
      chk("t6_pop", 64'(last_pop), 64'd1);
`ifdef PACKER_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("t6_wait%0d", k), 64'(out_valid), 64'd0);
      end
      tick();
      chk_word("t6", 32'h0000005A, 3'd1);
`else
      repeat (30) tick();
      chk("t6_no_timeout_valid", 64'(out_valid), 64'd0);
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
